mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two requesters:
  - the CPU pulse sequencer (operand/instruction fetch and result write);
  - the operator console (panel load and inspect).
- Each access is a latched, single-outstanding transaction with a req/ack handshake toward memory.
- A one-cycle finish pulse goes back to the owning requester, feeding the sequencer's mem_finish input.
- Sits between the pulse/control unit, the console logic and the memory controller.

Parameters:
- ADDR_W, 11, memory word address width.
- DATA_W, 31, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request, level; held until cpu_finish.
- cpu_we  in  1  CPU access is a write (1) or read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last CPU read data, registered.
- cpu_finish  out  1  one-cycle completion pulse to CPU.
- con_req, con_we, con_addr, con_wdata  in  1/1/ADDR_W/DATA_W  console request, same rules as CPU.
- con_rdata  out  DATA_W  last console read data, registered.
- con_finish  out  1  one-cycle completion pulse to console.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  latched write flag.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- owner_con  out  1  current/last owner: 0 = CPU, 1 = console.
- busy  out  1  state != IDLE.
- ack_err  out  1  sticky: mem_ack seen outside WAIT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: all outputs 0; state = IDLE; rdata registers 0. Reset mid-transaction:
  - immediately drops mem_req and any finish pulse;
  - abandons the transaction; no finish is issued after release.
- State machine (3 states):
  - IDLE:
    - if any request is present, pick the winner;
    - latch its we/addr/wdata into the mem_* registers and set owner_con;
    - go to WAIT.
    - No request: stay in IDLE.
  - WAIT:
    - mem_req = 1;
    - on mem_ack, latch mem_rdata into the owner's rdata register if mem_we = 0, then go to DONE;
    - otherwise stay in WAIT. No timeout.
  - DONE:
    - owner's finish = 1 for exactly this cycle;
    - go to IDLE unconditionally.
- Arbitration (default, fixed priority): CPU wins whenever cpu_req = 1.
- Latency:
  - request seen in IDLE at cycle t → mem_req high from t+1;
  - ack at cycle a ≥ t+1 → finish at a+1 → IDLE at a+2.
  - Minimum request-to-finish is 2 cycles.
  - mem_ack in the first cycle of mem_req is legal.
- Requester rules:
  - req, we, addr and wdata are sampled only in IDLE; later changes are ignored.
  - A requester must drop req the cycle after its finish; the arbiter does not re-sample until IDLE.
  - req dropped during WAIT: the transaction still completes and finish still pulses.
- Non-owner: its rdata and finish are untouched.
- Writes leave both rdata registers unchanged.
- ack_err:
  - set by mem_ack in IDLE or DONE;
  - that ack is otherwise ignored;
  - cleared only by reset.
- Simultaneous requests in IDLE: exactly one grant per transaction; the loser waits, request held.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - round-robin arbitration;
  - when both requests are present in IDLE, grant goes to the requester that did not own the previous transaction;
  - the first contest after reset goes to CPU;
  - a single requester is always granted immediately.
- Undefined: fixed CPU priority as above; the console can starve while the CPU streams requests.

Test Plan:
1. CPU read addr 0o17, mem_rdata 0x1234567 with ack 3 cycles after mem_req → mem_addr=0o17, mem_we=0; cpu_finish one cycle after ack; cpu_rdata=0x1234567; con_finish never asserts.
2. Console write addr 0o2000, data 0x7FFFFFFF, ack in first mem_req cycle → mem_we=1, mem_wdata=0x7FFFFFFF; con_finish 2 cycles after request sampled; con_rdata unchanged (0).
3. cpu_req and con_req rise together, both held → without macro: CPU then console. With MEM_ARB_RR_EN, three back-to-back contests grant CPU, console, CPU.
4. cpu_addr changed to 0o5 mid-WAIT, then cpu_req dropped before ack → mem_addr stays at the latched value; cpu_finish still pulses once.
5. resetn low during WAIT, then released, no ack → mem_req 0 immediately during reset; no finish after release; busy=0.
6. mem_ack pulsed while IDLE → ack_err=1 and stays 1; no finish; no rdata change; next normal transaction completes correctly.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Main-memory port bundle: CPU and console requester sides plus the memory side.
// The arbiter takes the slave view; the requesters/memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 31
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_finish;

    logic              con_req;
    logic              con_we;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_wdata;
    logic [DATA_W-1:0] con_rdata;
    logic              con_finish;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_finish,
        input  con_req, con_we, con_addr, con_wdata,
        output con_rdata, con_finish,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_finish,
        output con_req, con_we, con_addr, con_wdata,
        input  con_rdata, con_finish,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / console) arbiter for the single main-memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 31
) (
    input  logic clk,
    input  logic resetn,
    mem_port_arbiter_if.slave bus,
    output logic owner_con,
    output logic busy,
    output logic ack_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] con_rdata_q, con_rdata_d;
    logic              ack_err_q, ack_err_d;

    logic any_req;
    logic grant_con;

    assign any_req = bus.cpu_req | bus.con_req;

`ifdef MEM_ARB_RR_EN
    logic pref_con_q, pref_con_d;

    // Contested grant goes to whoever did not own the previous transaction.
    always_comb begin
        grant_con = bus.con_req;
        if (bus.cpu_req && bus.con_req)
            grant_con = pref_con_q;
    end

    // Remember which side should win the next contest.
    always_comb begin
        pref_con_d = pref_con_q;
        if (state_q == IDLE && any_req)
            pref_con_d = ~grant_con;
    end

    // Preference register; the first contest after reset goes to the CPU.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pref_con_q <= 1'b0;
        else
            pref_con_q <= pref_con_d;
    end
`else
    // Fixed priority: the console only wins when the CPU is not asking.
    always_comb begin
        grant_con = ~bus.cpu_req;
    end
`endif

    // Next-state, transaction latch and read-data capture.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        con_rdata_d = con_rdata_q;
        ack_err_d   = ack_err_q;

        if (bus.mem_ack && state_q != WAIT)
            ack_err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = grant_con;
                    we_d    = grant_con ? bus.con_we    : bus.cpu_we;
                    addr_d  = grant_con ? bus.con_addr  : bus.cpu_addr;
                    wdata_d = grant_con ? bus.con_wdata : bus.cpu_wdata;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        if (owner_q)
                            con_rdata_d = bus.mem_rdata;
                        else
                            cpu_rdata_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any open transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            cpu_rdata_q <= '0;
            con_rdata_q <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            con_rdata_q <= con_rdata_d;
            ack_err_q   <= ack_err_d;
        end
    end

    assign bus.mem_req    = (state_q == WAIT);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.con_rdata  = con_rdata_q;
    assign bus.cpu_finish = (state_q == DONE) & ~owner_q;
    assign bus.con_finish = (state_q == DONE) &  owner_q;

    assign owner_con = owner_q;
    assign busy      = (state_q != IDLE);
    assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests queue their expected
// completion; a negedge monitor checks each finish pulse against the queue head.
module tb_mem_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 31;

    logic clk;
    logic resetn;
    logic owner_con;
    logic busy;
    logic ack_err;

    int checks;
    int errors;
    int cyc;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .owner_con (owner_con),
        .busy      (busy),
        .ack_err   (ack_err)
    );

    typedef struct {
        logic          con;
        logic [DW-1:0] cpu_rd;
        logic [DW-1:0] con_rd;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            fin;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic con, input logic [DW-1:0] cpu_rd,
                        input logic [DW-1:0] con_rd, input logic [AW-1:0] addr,
                        input logic we, input logic [DW-1:0] wdata,
                        input int fin);
        exp_t e;
        e.con    = con;
        e.cpu_rd = cpu_rd;
        e.con_rd = con_rd;
        e.addr   = addr;
        e.we     = we;
        e.wdata  = wdata;
        e.fin    = fin;
        sb.push_back(e);
    endtask

    // Memory model: wait for mem_req (bounded), hold wt cycles, then ack once.
    task automatic serve(input int wt, input logic [DW-1:0] rd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mem_req_timeout: got 0 expected 1 within 20 cycles");
        end
        for (int i = 0; i < wt; i++) tick();
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
    endtask

    // Monitor: every finish pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.cpu_finish || bus.con_finish) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_finish: got cpu=%0b con=%0b expected none",
                         bus.cpu_finish, bus.con_finish);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("finish_who", {62'd0, bus.cpu_finish, bus.con_finish},
                    e.con ? 64'd1 : 64'd2);
                chk("finish_cycle", 64'(cyc), 64'(e.fin));
                chk("owner_con", 64'(owner_con), 64'(e.con));
                chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.cpu_rd));
                chk("con_rdata", 64'(bus.con_rdata), 64'(e.con_rd));
                chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                chk("mem_we", 64'(bus.mem_we), 64'(e.we));
                if (e.we)
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        checks = 0;
        errors = 0;
        cyc    = 0;
        resetn = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.con_req = 0; bus.con_we = 0; bus.con_addr = '0; bus.con_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ack = 0;

        // Reset state
        #3;
        chk("rst_mem_req", 64'(bus.mem_req), 0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 0);
        chk("rst_rdata", 64'({bus.cpu_rdata, bus.con_rdata}), 0);
        chk("rst_flags", 64'({bus.mem_we, owner_con, busy, ack_err}), 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // 1: CPU read 0o17, ack 3 cycles into mem_req
        t = cyc;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'o17;
        push(0, 31'h1234567, 31'h0, 11'o17, 0, 31'h0, t + 5);
        serve(3, 31'h1234567);
        bus.cpu_req = 0;
        tick();

        // 2: console write 0o2000, ack in first mem_req cycle
        t = cyc;
        bus.con_req = 1; bus.con_we = 1; bus.con_addr = 11'o2000;
        bus.con_wdata = 31'h7FFFFFFF;
        push(1, 31'h1234567, 31'h0, 11'o2000, 1, 31'h7FFFFFFF, t + 2);
        serve(0, 31'h0);
        bus.con_req = 0;
        tick();

        // 3: simultaneous requests
        t = cyc;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'o1;
        bus.con_req = 1; bus.con_we = 0; bus.con_addr = 11'o2;
        push(0, 31'h111, 31'h0, 11'o1, 0, 31'h0, t + 2);
        push(1, 31'h111, 31'h222, 11'o2, 0, 31'h0, t + 5);
`ifdef MEM_ARB_RR_EN
        push(0, 31'h333, 31'h222, 11'o1, 0, 31'h0, t + 8);
        serve(0, 31'h111);
        serve(0, 31'h222);
        serve(0, 31'h333);
        bus.cpu_req = 0;
        bus.con_req = 0;
`else
        serve(0, 31'h111);
        bus.cpu_req = 0;
        serve(0, 31'h222);
        bus.con_req = 0;
`endif
        tick();
        chk("t3_idle", 64'(busy), 0);

        // 4: address change and req drop during WAIT are ignored
        t = cyc;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'o100;
        push(0, 31'h55AA, 31'h222, 11'o100, 0, 31'h0, t + 4);
        tick();
        chk("t4_mem_req", 64'(bus.mem_req), 1);
        bus.cpu_addr = 11'o5;
        tick();
        chk("t4_addr_held", 64'(bus.mem_addr), 64'(11'o100));
        bus.cpu_req = 0;
        tick();
        bus.mem_rdata = 31'h55AA;
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        tick();

        // 5: reset during WAIT abandons the transaction
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'o3;
        bus.cpu_wdata = 31'h5;
        tick();
        chk("t5_wait_req", 64'({bus.mem_req, busy}), 3);
        resetn = 1'b0;
        #1;
        chk("t5_rst_req", 64'(bus.mem_req), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_fin", 64'({bus.cpu_finish, bus.con_finish}), 0);
        bus.cpu_req = 0;
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_post_busy", 64'(busy), 0);
        chk("t5_post_req", 64'(bus.mem_req), 0);

        // 6: stray ack in IDLE sets sticky error, nothing else
        bus.mem_rdata = 31'h0DEAD;
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        chk("t6_ack_err", 64'(ack_err), 1);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_rdata", 64'({bus.cpu_rdata, bus.con_rdata}), 0);
        tick();
        t = cyc;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'o777;
        bus.cpu_wdata = 31'h0ABCDEF;
        push(0, 31'h0, 31'h0, 11'o777, 1, 31'h0ABCDEF, t + 3);
        serve(1, 31'h1FFFFFFF);
        bus.cpu_req = 0;
        tick(); tick();
        chk("t6_ack_err_sticky", 64'(ack_err), 1);
        chk("t6_write_rdata", 64'(bus.cpu_rdata), 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
